// File: rtl/sdpram_pkg.sv
// -----------------------------------------------------------------------------
// sdpram_pkg
// Shared types and helpers for the simple dual-port byte RAM and its readers.
//   rd_state_e    : read-sequencer state encoding (IDLE/RUN/DRAIN/FIN)
//   sdpram_addr_w : word-address width for a RAM of size_bytes bytes read
//                   through a port of word_w bits (log2 of the word count)
// No ports (package).
// -----------------------------------------------------------------------------
package sdpram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } rd_state_e;

    // Same formula the RAM uses for its read port, so both sides always agree.
    function automatic int sdpram_addr_w(input int size_bytes, input int word_w);
        return $clog2((size_bytes * 32'd8) / word_w);
    endfunction

endpackage

// File: rtl/sdpram_skid_fifo.sv
// -----------------------------------------------------------------------------
// sdpram_skid_fifo
// Two-entry FIFO absorbing the RAM read latency. Entry 0 is always the head;
// simultaneous push and pop are supported at any occupancy.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (clears storage too)
//   push      : write push_data this cycle
//   push_data : W-bit entry to store
//   pop       : remove the head this cycle (ignored when empty)
//   head      : current head entry
//   count     : occupancy 0..2
// -----------------------------------------------------------------------------
module sdpram_skid_fifo #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem0_r;
    logic [W-1:0] mem1_r;
    logic [1:0]   count_r;

    assign head  = mem0_r;
    assign count = count_r;

    // Storage and occupancy update; entries shift toward slot 0 on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem0_r  <= {W{1'b0}};
            mem1_r  <= {W{1'b0}};
            count_r <= 2'd0;
        end else begin
            case (count_r)
                2'd0: begin
                    if (push) begin
                        mem0_r  <= push_data;
                        count_r <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        mem0_r <= push_data;
                    end else if (push) begin
                        mem1_r  <= push_data;
                        count_r <= 2'd2;
                    end else if (pop) begin
                        count_r <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        mem0_r <= mem1_r;
                        if (push) begin
                            mem1_r <= push_data;
                        end else begin
                            count_r <= 2'd1;
                        end
                    end
                end
                default: begin
                    count_r <= 2'd0;
                end
            endcase
        end
    end

    sdpram_skid_fifo_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .count (count_r)
    );

endmodule

// File: rtl/sdpram_skid_fifo_chk.sv
// -----------------------------------------------------------------------------
// sdpram_skid_fifo_chk
// Simulation-only protocol checker for the 2-entry skid FIFO.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   push     : write strobe into the FIFO
//   pop      : read strobe out of the FIFO
//   count    : current occupancy (0..2)
// -----------------------------------------------------------------------------
module sdpram_skid_fifo_chk (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] count
);

    // A push into a full buffer without a matching pop would lose a word.
    no_overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == 2'd2)));

    // Popping an empty buffer would emit a stale word.
    no_underflow_a: assert property (@(posedge clk) disable iff (rst)
        !(pop && (count == 2'd0)));

    // Occupancy can only ever be 0, 1 or 2.
    count_range_a: assert property (@(posedge clk) disable iff (rst)
        (count != 2'd3));

endmodule

// File: rtl/sdpram_stream_reader.sv
// -----------------------------------------------------------------------------
// sdpram_stream_reader
// Read-side sequencer for the simple dual-port byte RAM. On start it reads
// len words from base_addr (wrapping modulo the RAM depth), hides the RAM's
// one-cycle latency in a 2-entry skid FIFO and emits a valid/ready stream
// with m_last on the final beat, then pulses done.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : request pulse, sampled only in IDLE
//   base_addr  : first word address (sampled with start)
//   len        : word count 0..DEPTH (sampled with start)
//   busy       : transfer active (RUN, DRAIN, FIN)
//   done       : one-cycle completion pulse
//   ram_en     : RAM read enable
//   ram_addr   : RAM read address
//   ram_data   : RAM read data, valid the cycle after ram_en
//   m_valid    : stream valid
//   m_ready    : stream ready from the consumer
//   m_data     : stream data
//   m_last     : final beat marker
// -----------------------------------------------------------------------------
module sdpram_stream_reader
    import sdpram_pkg::*;
#(
    parameter int OUTPUT_DATA_W = 8,
    parameter int SIZE          = 1024,
    parameter int ADDR_W        = sdpram_addr_w(SIZE, OUTPUT_DATA_W),
    parameter int LEN_W         = ADDR_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [LEN_W-1:0]         len,
    output logic                     busy,
    output logic                     done,
    output logic                     ram_en,
    output logic [ADDR_W-1:0]        ram_addr,
    input  logic [OUTPUT_DATA_W-1:0] ram_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [OUTPUT_DATA_W-1:0] m_data,
    output logic                     m_last
);

    rd_state_e              state_r;
    logic [ADDR_W-1:0]      base_r;
    logic [LEN_W-1:0]       len_r;
    logic [LEN_W-1:0]       issued_r;
    logic [LEN_W-1:0]       beats_r;
    logic                   inflight_r;

    logic [1:0]             fifo_count_s;
    logic [OUTPUT_DATA_W:0] head_s;
    logic [OUTPUT_DATA_W:0] push_entry_s;
    logic                   pop_s;
    logic                   room_s;
    logic                   issue_s;
    logic                   beat_last_s;

    assign pop_s    = m_valid & m_ready;
    assign m_valid  = (fifo_count_s != 2'd0);
    assign m_data   = head_s[OUTPUT_DATA_W-1:0];
    // The head slot keeps its old flag after the final pop, so gate with valid.
    assign m_last   = m_valid & head_s[OUTPUT_DATA_W];
    assign busy     = (state_r != IDLE);
    assign done     = (state_r == FIN);
    assign ram_en   = issue_s;
    // Truncation to ADDR_W gives the wrap from DEPTH-1 back to 0.
    assign ram_addr = base_r + issued_r[ADDR_W-1:0];

    // beats_r counts captured words, so it is the index of the word being pushed.
    assign beat_last_s  = (beats_r == (len_r - LEN_W'(1)));
    assign push_entry_s = {beat_last_s, ram_data};

    // Issue a read only while the FIFO plus the in-flight read, net of this
    // cycle's pop, leaves space; computed in 3 bits so the subtraction never wraps.
    always_comb begin
        room_s  = (({1'b0, fifo_count_s} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s}));
        issue_s = 1'b0;
        if ((state_r == RUN) && (issued_r < len_r) && room_s) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Control FSM, request capture, issue/capture counters and in-flight flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            base_r     <= {ADDR_W{1'b0}};
            len_r      <= {LEN_W{1'b0}};
            issued_r   <= {LEN_W{1'b0}};
            beats_r    <= {LEN_W{1'b0}};
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                issued_r <= issued_r + LEN_W'(1);
            end
            if (inflight_r) begin
                beats_r <= beats_r + LEN_W'(1);
            end

            case (state_r)
                IDLE: begin
                    if (start) begin
                        base_r   <= base_addr;
                        len_r    <= len;
                        issued_r <= {LEN_W{1'b0}};
                        beats_r  <= {LEN_W{1'b0}};
                        // A zero-length request spends one cycle in DRAIN so that
                        // done lands two cycles after start, like a real drain.
                        state_r  <= (len == {LEN_W{1'b0}}) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    // The final beat cannot be popped before this exit: it is
                    // pushed no earlier than the cycle DRAIN is entered.
                    if (issued_r == len_r) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((len_r == {LEN_W{1'b0}}) || (pop_s && m_last)) begin
                        state_r <= FIN;
                    end
                end
                FIN: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    sdpram_skid_fifo #(
        .W (OUTPUT_DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_r),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (fifo_count_s)
    );

endmodule

// File: tb/tb_sdpram_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_sdpram_stream_reader
// Self-checking bench: a table of directed transfers, a hand-written
// mid-transfer reset sequence and a batch of random transfers with random
// back-pressure, each compared against an address/data model of the RAM.
// -----------------------------------------------------------------------------
module tb_sdpram_stream_reader;

    localparam int W      = 8;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [W-1:0]      ram_data;
    logic              m_valid;
    logic              m_ready;
    logic [W-1:0]      m_data;
    logic              m_last;

    logic [W-1:0] mem [0:DEPTH-1];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int base;
        int ln;
        int rmode;      // 0: always ready, 1: 1,0,0,1 pattern, 2: random
        int restart;    // cycle of an extra start while busy, -1 for none
        int exp_first;  // cycle of first beat, -1 if not timed
        int exp_done;   // cycle of done, -1 if not timed
    } vec_t;

    always #5 clk = ~clk;

    sdpram_stream_reader #(
        .OUTPUT_DATA_W (W),
        .SIZE          (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ram_en    (ram_en),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    // RAM read port: one-cycle latency, zero when not enabled.
    always @(posedge clk) begin
        ram_data <= ram_en ? mem[ram_addr] : 8'h00;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return ((c % 4) == 0) || ((c % 4) == 3);
            default: return ($urandom_range(0, 2) != 0);
        endcase
    endfunction

    task automatic run_xfer(input string tag, input int base, input int ln, input int mode,
                            input int restart, input int exp_first, input int exp_done);
        logic [W-1:0] data_q[$];
        logic         last_q[$];
        int           addr_q[$];
        int iss = 0, pops = 0;
        int issue_viol = 0, stall_viol = 0, busy_viol = 0;
        int done_cnt = 0, done_cyc = -1, first_cyc = -1, valid_seen = 0;
        int data_err = 0, last_err = 0, addr_err = 0;
        int budget;
        bit finished = 1'b0;
        bit prev_stall = 1'b0;
        logic [W-1:0] prev_data = 8'h00;
        logic prev_last = 1'b0;

        budget = ln * 8 + 50;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        len       = LEN_W'(ln);
        m_ready   = ready_for(mode, 0);

        for (int c = 0; c < budget && !finished; c++) begin
            @(negedge clk);
            if (ram_en) begin
                addr_q.push_back(int'(ram_addr));
                if ((iss - pops - int'(m_valid && m_ready)) >= 2) issue_viol++;
                iss++;
            end
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
                stall_viol++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid) valid_seen++;
            if (m_valid && m_ready) begin
                data_q.push_back(m_data);
                last_q.push_back(m_last);
                if (first_cyc < 0) first_cyc = c;
                pops++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
                if (!busy) busy_viol++;
                finished = 1'b1;
            end
            @(posedge clk); #1;
            // Request fields are junk after the start cycle: only the sampled copy counts.
            start     = ((c + 1) == restart);
            base_addr = ADDR_W'($urandom);
            len       = LEN_W'($urandom);
            m_ready   = ready_for(mode, c + 1);
        end
        start = 1'b0;

        check({tag, " finished"}, finished, 1);
        check({tag, " beats"}, data_q.size(), ln);
        for (int k = 0; k < data_q.size(); k++) begin
            if (data_q[k] !== mem[(base + k) % DEPTH]) data_err++;
            if (last_q[k] !== (k == ln - 1)) last_err++;
        end
        check({tag, " data errors"}, data_err, 0);
        check({tag, " last errors"}, last_err, 0);
        check({tag, " reads issued"}, addr_q.size(), ln);
        for (int k = 0; k < addr_q.size(); k++) begin
            if (addr_q[k] != ((base + k) % DEPTH)) addr_err++;
        end
        check({tag, " addr errors"}, addr_err, 0);
        check({tag, " issue-rule violations"}, issue_viol, 0);
        check({tag, " stall instability"}, stall_viol, 0);
        check({tag, " done pulses"}, done_cnt, 1);
        check({tag, " done without busy"}, busy_viol, 0);
        if (exp_first >= 0) check({tag, " first beat cycle"}, first_cyc, exp_first);
        if (exp_done >= 0) check({tag, " done cycle"}, done_cyc, exp_done);
        if (ln == 0) check({tag, " valid cycles"}, valid_seen, 0);
        @(negedge clk);
        check({tag, " busy after done"}, busy, 0);
        check({tag, " done after done"}, done, 0);
    endtask

    initial begin
        vec_t vecs[6];
        int got, seen_v, seen_d, rb, rl, rr;

        vecs[0] = '{32'h10,      4,     0, -1,  3, 7};
        vecs[1] = '{DEPTH - 2,   4,     0, -1,  3, 7};
        vecs[2] = '{5,           6,     1, -1, -1, -1};
        vecs[3] = '{32'h20,      0,     0, -1, -1, 2};
        vecs[4] = '{0,           DEPTH, 0, 100, 3, DEPTH + 3};
        vecs[5] = '{DEPTH - 1,   1,     0, -1,  3, 4};

        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);

        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        m_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset ram_en", ram_en, 0);
        check("reset ram_addr", ram_addr, 0);
        check("reset m_valid", m_valid, 0);
        check("reset m_data", m_data, 0);
        check("reset m_last", m_last, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_xfer($sformatf("vec%0d", i), vecs[i].base, vecs[i].ln, vecs[i].rmode,
                     vecs[i].restart, vecs[i].exp_first, vecs[i].exp_done);
        end

        // Reset after the third of eight beats: stream dropped, no done.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'h040; len = 11'd8; m_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) got++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("midrst beats before reset", got, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst ram_en", ram_en, 0);
        check("midrst ram_addr", ram_addr, 0);
        check("midrst m_valid", m_valid, 0);
        check("midrst m_data", m_data, 0);
        check("midrst m_last", m_last, 0);
        seen_v = 0; seen_d = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (m_valid) seen_v++;
            if (done || busy) seen_d++;
        end
        check("midrst later valid", seen_v, 0);
        check("midrst later done/busy", seen_d, 0);
        run_xfer("after_rst", 32'h80, 5, 0, -1, 3, 8);

        // Random contents, requests and back-pressure.
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        for (int t = 0; t < 24; t++) begin
            rb = $urandom_range(0, DEPTH - 1);
            rl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
            rr = $urandom_range(1, rl + 2);
            run_xfer($sformatf("rand%0d", t), rb, rl, 2, rr, -1, (rl == 0) ? 2 : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
